// File: rtl/piton_int_pkg.sv
// rtl/piton_int_pkg.sv - interrupt word layout and constants shared by the sender and the core-side decoder
package piton_int_pkg;

  localparam logic [1:0] INT_TYPE_RESET = 2'b01;
  localparam logic [5:0] INT_VEC_POR    = 6'b000001;

  localparam int INT_TYPE_LSB = 16;
  localparam int INT_TID_LSB  = 8;
  localparam int INT_VEC_LSB  = 0;

  typedef struct packed {
    logic [45:0] rsvd_hi;
    logic [1:0]  int_type;
    logic [7:0]  tid;
    logic [1:0]  rsvd_lo;
    logic [5:0]  vec;
  } int_vec_t;

  typedef enum logic [1:0] {
    WAIT_INIT,
    SEND,
    DONE
  } wake_state_e;

  function automatic int_vec_t make_int_word(input logic [1:0] int_type,
                                             input logic [7:0] tid,
                                             input logic [5:0] vec);
    return int_vec_t'((64'(int_type) << INT_TYPE_LSB) |
                      (64'(tid)      << INT_TID_LSB)  |
                      (64'(vec)      << INT_VEC_LSB));
  endfunction

endpackage

// File: rtl/piton_int_out_reg.sv
// rtl/piton_int_out_reg.sv - 1-entry valid/ready output register shared by the boot and software paths
module piton_int_out_reg
  import piton_int_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_l,
  input  logic     in_val,
  input  int_vec_t in_data,
  output logic     in_rdy,
  output logic     out_val,
  output int_vec_t out_data,
  input  logic     out_rdy
);

  // Accept a new word whenever the slot is empty or is draining this cycle.
  assign in_rdy = !out_val || out_rdy;

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      out_val  <= 1'b0;
      out_data <= '0;
    end else if (in_val && in_rdy) begin
      out_val  <= 1'b1;
      out_data <= in_data;
    end else if (out_rdy) begin
      out_val  <= 1'b0;
    end
  end

endmodule

// File: rtl/piton_wakeup_int_sender.sv
// rtl/piton_wakeup_int_sender.sv - issues power-on wakeup interrupts to the tiles, then forwards software interrupts
module piton_wakeup_int_sender
  import piton_int_pkg::*;
#(
  parameter int NumTiles        = 1,
  parameter int InitDelayCycles = 32768,
  parameter int WakeAllTiles    = 0,
  parameter int TileIdWidth     = 8
) (
  input  logic        clk_i,
  input  logic        reset_l,
  output logic        int_val_o,
  output logic [63:0] int_data_o,
  input  logic        int_rdy_i,
  input  logic        sw_val_i,
  input  logic [63:0] sw_data_i,
  output logic        sw_rdy_o,
  output logic        boot_done_o
);

  localparam int CntWidth = $clog2(InitDelayCycles + 1);
  localparam int IdxWidth = (NumTiles > 1) ? $clog2(NumTiles) : 1;

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(InitDelayCycles - 1);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(InitDelayCycles);
  localparam logic [IdxWidth-1:0] IdxLast = IdxWidth'(NumTiles - 1);

  if (NumTiles < 1 || NumTiles > 2**TileIdWidth || TileIdWidth > 8 ||
      InitDelayCycles < 1) begin : g_param_check
    $error("piton_wakeup_int_sender: illegal parameter combination");
  end

  wake_state_e         state_q, state_d;
  logic [CntWidth-1:0] cnt_q;
  logic [IdxWidth-1:0] idx_q, idx_d;
  logic                more_tiles;
  logic                ld_val, ld_rdy;
  int_vec_t            ld_data, out_data;

  function automatic int_vec_t boot_word(input logic [IdxWidth-1:0] idx);
    return make_int_word(INT_TYPE_RESET, 8'(idx), INT_VEC_POR);
  endfunction

  assign more_tiles = (WakeAllTiles != 0) && (idx_q != IdxLast);

  // The first boot word is loaded on the last wait cycle so it is visible
  // exactly InitDelayCycles edges after reset release.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ld_val   = 1'b0;
    ld_data  = boot_word(idx_q);
    sw_rdy_o = 1'b0;
    unique case (state_q)
      WAIT_INIT: begin
        if (cnt_q == CntLast) begin
          ld_val  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (int_val_o && int_rdy_i) begin
          if (more_tiles) begin
            idx_d   = idx_q + IdxWidth'(1);
            ld_val  = 1'b1;
            ld_data = boot_word(idx_q + IdxWidth'(1));
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        ld_val   = sw_val_i;
        ld_data  = sw_data_i;
        sw_rdy_o = ld_rdy;
      end
      default: state_d = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= WAIT_INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == WAIT_INIT && cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end
    end
  end

  piton_int_out_reg u_out_reg (
    .clk_i    (clk_i),
    .reset_l  (reset_l),
    .in_val   (ld_val),
    .in_data  (ld_data),
    .in_rdy   (ld_rdy),
    .out_val  (int_val_o),
    .out_data (out_data),
    .out_rdy  (int_rdy_i)
  );

  assign int_data_o  = out_data;
  assign boot_done_o = (state_q == DONE);

endmodule

// File: tb/tb_piton_wakeup_int_sender.sv
// tb/tb_piton_wakeup_int_sender.sv - self-checking bench for the wakeup interrupt sender
module tb_piton_wakeup_int_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // a: default parameters, b: 4 tiles / 16 cycles / wake all, c: 3 tiles / 1 cycle / wake all
  logic        reset_a, val_a, rdy_a, sw_val_a, sw_rdy_a, done_a;
  logic [63:0] data_a, sw_data_a;
  logic        reset_b, val_b, rdy_b, sw_val_b, sw_rdy_b, done_b;
  logic [63:0] data_b, sw_data_b;
  logic        reset_c, val_c, rdy_c, sw_val_c, sw_rdy_c, done_c;
  logic [63:0] data_c, sw_data_c;

  piton_wakeup_int_sender dut_a (
    .clk_i(clk), .reset_l(reset_a), .int_val_o(val_a), .int_data_o(data_a), .int_rdy_i(rdy_a),
    .sw_val_i(sw_val_a), .sw_data_i(sw_data_a), .sw_rdy_o(sw_rdy_a), .boot_done_o(done_a));

  piton_wakeup_int_sender #(.NumTiles(4), .InitDelayCycles(16), .WakeAllTiles(1)) dut_b (
    .clk_i(clk), .reset_l(reset_b), .int_val_o(val_b), .int_data_o(data_b), .int_rdy_i(rdy_b),
    .sw_val_i(sw_val_b), .sw_data_i(sw_data_b), .sw_rdy_o(sw_rdy_b), .boot_done_o(done_b));

  piton_wakeup_int_sender #(.NumTiles(3), .InitDelayCycles(1), .WakeAllTiles(1)) dut_c (
    .clk_i(clk), .reset_l(reset_c), .int_val_o(val_c), .int_data_o(data_c), .int_rdy_i(rdy_c),
    .sw_val_i(sw_val_c), .sw_data_i(sw_data_c), .sw_rdy_o(sw_rdy_c), .boot_done_o(done_c));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Boot word from the interrupt format: type 01 at [17:16], tile at [15:8], vector 1.
  function automatic logic [63:0] boot_w(input int tile);
    return (64'd1 << 16) | (64'(tile) << 8) | 64'd1;
  endfunction

  task automatic run_default();
    int k = 0;
    rdy_a = 1'b1;
    reset_a = 1'b1;
    while (!val_a && k < 33000) begin
      @(negedge clk);
      k++;
    end
    check("a_first_latency", k, 32768);
    check("a_boot_word", data_a, 64'h0000_0000_0001_0001);
    check("a_done_early", done_a, 1'b0);
    check("a_sw_rdy_boot", sw_rdy_a, 1'b0);
    @(negedge clk);
    check("a_val_after", val_a, 1'b0);
    check("a_done", done_a, 1'b1);
    repeat (5) @(negedge clk);
    check("a_single_word", val_a, 1'b0);
    check("a_sw_rdy_done", sw_rdy_a, 1'b1);
  endtask

  task automatic run_multi();
    logic [63:0] got[$];
    int k = 0, held = 0, first = -1, last = -1, sw_seen = 0;
    sw_val_b  = 1'b1;
    sw_data_b = 64'h0000_DEAD_0001_0203;
    rdy_b     = 1'b1;
    reset_b   = 1'b1;
    while (got.size() < 4 && k < 300) begin
      @(negedge clk);
      k++;
      if (sw_rdy_b) sw_seen++;
      if (val_b && first < 0) first = k;
      if (val_b && data_b == boot_w(2) && held < 50) begin
        rdy_b = 1'b0;
        held++;
      end else if (val_b) begin
        rdy_b = 1'b1;
        got.push_back(data_b);
        last = k;
      end else begin
        rdy_b = 1'b1;
      end
    end
    check("b_first_latency", first, 16);
    check("b_word_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      check($sformatf("b_word%0d", i), got[i], boot_w(i));
    check("b_hold_cycles", held, 50);
    check("b_back_to_back", last - first, 53);
    check("b_sw_held_off", sw_seen, 0);
    @(negedge clk);
    check("b_done", done_b, 1'b1);
    check("b_val_idle", val_b, 1'b0);
  endtask

  typedef struct {
    logic        sw_val;
    logic [63:0] sw_data;
    logic        rdy;
    logic        exp_sw_rdy;
    logic        exp_val;
    logic [63:0] exp_data;
  } vec_t;

  task automatic run_table();
    vec_t tbl[9];
    tbl[0] = '{1'b1, 64'h0000_DEAD_0001_0203, 1'b0, 1'b1, 1'b1, 64'h0000_DEAD_0001_0203};
    tbl[1] = '{1'b1, 64'h0000_0000_0000_00A1, 1'b0, 1'b0, 1'b1, 64'h0000_DEAD_0001_0203};
    tbl[2] = '{1'b1, 64'h0000_0000_0000_00A1, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_00A1};
    tbl[3] = '{1'b1, 64'h0000_0000_0000_00A2, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_00A2};
    tbl[4] = '{1'b1, 64'h0000_0000_0000_00A3, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_00A3};
    tbl[5] = '{1'b0, 64'h0,                   1'b1, 1'b1, 1'b0, 64'h0};
    tbl[6] = '{1'b0, 64'h0,                   1'b0, 1'b1, 1'b0, 64'h0};
    tbl[7] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[8] = '{1'b0, 64'h0,                   1'b1, 1'b1, 1'b0, 64'h0};
    for (int i = 0; i < 9; i++) begin
      sw_val_b  = tbl[i].sw_val;
      sw_data_b = tbl[i].sw_data;
      rdy_b     = tbl[i].rdy;
      #1;
      check($sformatf("tbl%0d_sw_rdy", i), sw_rdy_b, tbl[i].exp_sw_rdy);
      @(negedge clk);
      check($sformatf("tbl%0d_val", i), val_b, tbl[i].exp_val);
      if (tbl[i].exp_val) check($sformatf("tbl%0d_data", i), data_b, tbl[i].exp_data);
      check($sformatf("tbl%0d_done", i), done_b, 1'b1);
    end
  endtask

  task automatic wait_first_b(input string tag);
    int k = 0;
    while (!val_b && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, 16);
    check({tag, "_tile0"}, data_b, boot_w(0));
  endtask

  task automatic run_reset();
    sw_val_b = 1'b0;
    rdy_b    = 1'b1;
    reset_b  = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    wait_first_b("r1");
    @(negedge clk);
    check("r1_tile1", data_b, boot_w(1));
    #2 reset_b = 1'b0;
    #1;
    check("r_val_clr", val_b, 1'b0);
    check("r_data_clr", data_b, 64'h0);
    check("r_done_clr", done_b, 1'b0);
    check("r_sw_rdy_clr", sw_rdy_b, 1'b0);
    @(negedge clk);
    reset_b = 1'b1;
    wait_first_b("r2");
    for (int t = 1; t < 4; t++) begin
      @(negedge clk);
      check($sformatf("r2_tile%0d", t), data_b, boot_w(t));
    end
    @(negedge clk);
    check("r2_done", done_b, 1'b1);
  endtask

  // Reference: an ordered queue of words the output must present, at most one deep.
  task automatic run_random();
    localparam int N = 3;
    localparam int D = 1;
    logic [63:0] mq[$];
    int edges = 0, boot_sent = 0;
    bit m_done = 0, exp_sw_rdy, xfer, acc;
    rdy_c = 1'b0; sw_val_c = 1'b0; sw_data_c = '0;
    reset_c = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      check("c_val", val_c, mq.size() != 0);
      if (mq.size() != 0) check("c_data", data_c, mq[0]);
      check("c_done", done_c, m_done);
      rdy_c = 1'($urandom_range(0, 1));
      if (!sw_val_c && $urandom_range(0, 2) != 0) begin
        sw_val_c  = 1'b1;
        sw_data_c = {$urandom, $urandom};
      end
      exp_sw_rdy = m_done && (mq.size() == 0 || rdy_c);
      #1;
      check("c_sw_rdy", sw_rdy_c, exp_sw_rdy);
      edges++;
      xfer = (mq.size() != 0) && rdy_c;
      acc  = sw_val_c && exp_sw_rdy;
      if (xfer) begin
        void'(mq.pop_front());
        if (boot_sent < N) begin
          boot_sent++;
          if (boot_sent < N) mq.push_back(boot_w(boot_sent));
          else m_done = 1;
        end
      end
      if (acc) mq.push_back(sw_data_c);
      if (edges == D) mq.push_back(boot_w(0));
      @(negedge clk);
      if (acc) sw_val_c = 1'b0;
    end
    check("c_boot_complete", boot_sent, N);
  endtask

  initial begin
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    rdy_a = 1'b0; sw_val_a = 1'b0; sw_data_a = '0;
    rdy_b = 1'b0; sw_val_b = 1'b0; sw_data_b = '0;
    rdy_c = 1'b0; sw_val_c = 1'b0; sw_data_c = '0;
    repeat (3) @(negedge clk);
    check("rst_val_a", val_a, 1'b0);
    check("rst_data_a", data_a, 64'h0);
    check("rst_sw_rdy_a", sw_rdy_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_val_b", val_b, 1'b0);
    check("rst_done_b", done_b, 1'b0);
    check("rst_val_c", val_c, 1'b0);
    run_default();
    run_multi();
    run_table();
    run_reset();
    run_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
